// File: rtl/div8b4b.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Start/done handshake; all outputs registered.
module div8b4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dvd,
  input  logic [3:0] dvs,
  output logic       busy,
  output logic       done,
  output logic [7:0] quo,
  output logic [3:0] rem,
  output logic       div0
);

  localparam int unsigned QW = 8;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DIVZ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] p_q, p_d;
  logic [QW-1:0] q_q, q_d;
  logic [DW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          div0_q, div0_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW:0]   trial;

  // Partial remainder never reaches D, so its top bit is always zero and is not stored.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    trial   = {p_q, q_q[QW-1]};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dvs != '0) begin
            d_d     = dvs;
            q_d     = dvd;
            p_d     = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            state_d = S_DIVZ;
          end
        end
      end
      S_CALC: begin
        if (trial >= {1'b0, d_q}) begin
          p_d = DW'(trial - {1'b0, d_q});
          q_d = {q_q[QW-2:0], 1'b1};
        end else begin
          p_d = trial[DW-1:0];
          q_d = {q_q[QW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(7)) begin
          quo_d   = q_d;
          rem_d   = p_d;
          div0_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      // One-cycle hold so a zero divisor reports with a latency of one cycle.
      S_DIVZ: begin
        quo_d   = '1;
        rem_d   = '1;
        div0_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_div8b4b.sv
// Directed self-checking bench for div8b4b: latency, results, corners, divide-by-zero,
// ignored start while busy, held start, and asynchronous abort.
module tb_div8b4b;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dvd;
  logic [3:0] dvs;
  logic       busy;
  logic       done;
  logic [7:0] quo;
  logic [3:0] rem;
  logic       div0;

  int n_tests = 0;
  int n_fail  = 0;

  div8b4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dvd   (dvd),
    .dvs   (dvs),
    .busy  (busy),
    .done  (done),
    .quo   (quo),
    .rem   (rem),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done after an accepted start edge; returns cycles and busy-high samples.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = busy ? 1 : 0;
    for (int n = 1; n <= 30 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) lat = n;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er, input logic ed0,
                        input int elat);
    int lat;
    int bcnt;
    @(negedge clk);
    start = 1'b1; dvd = a; dvs = b;
    @(posedge clk); #1;
    start = 1'b0; dvd = 8'h00; dvs = 4'h0;
    wait_done(lat, bcnt);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " quo"}, 32'(quo), 32'(eq));
    chk({tag, " rem"}, 32'(rem), 32'(er));
    chk({tag, " div0"}, 32'(div0), 32'(ed0));
    chk({tag, " busy cycles"}, 32'(bcnt), 32'(elat + 1));
    @(posedge clk); #1;
    chk({tag, " done drops"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcnt;
    rst_n = 1'b0; start = 1'b0; dvd = 8'h00; dvs = 4'h0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div0", 32'(div0), 32'd0);
    chk("reset quo", 32'(quo), 32'h00);
    chk("reset rem", 32'(rem), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; dvd = 8'd200; dvs = 4'd7;
    #2;
    chk("no edge busy", 32'(busy), 32'd0);
    chk("no edge quo", 32'(quo), 32'h00);
    start = 1'b0;

    run_op("200/7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
    run_op("255/1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
    run_op("5/13", 8'd5, 4'd13, 8'd0, 4'd5, 1'b0, 8);
    run_op("255/15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);
    run_op("0/9", 8'd0, 4'd9, 8'd0, 4'd0, 1'b0, 8);
    run_op("5A/0", 8'h5A, 4'd0, 8'hFF, 4'hF, 1'b1, 1);
    run_op("100/3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8);

    // Second start during CALC must be ignored; results hold while busy.
    @(negedge clk);
    start = 1'b1; dvd = 8'd200; dvs = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dvd = 8'd9; dvs = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold quo in calc", 32'(quo), 32'd33);
    chk("hold rem in calc", 32'(rem), 32'd1);
    lat = -1;
    for (int n = 4; n <= 30 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (done) lat = n;
    end
    chk("ignore latency", 32'(lat), 32'd8);
    chk("ignore quo", 32'(quo), 32'd28);
    chk("ignore rem", 32'(rem), 32'd4);
    @(posedge clk); #1;

    // Start held high: next op taken at the first edge seen in IDLE, with inputs changed after sampling.
    @(negedge clk);
    start = 1'b1; dvd = 8'd200; dvs = 4'd7;
    @(posedge clk); #1;
    dvd = 8'd255; dvs = 4'd15;
    wait_done(lat, bcnt);
    chk("held first latency", 32'(lat), 32'd8);
    chk("held first quo", 32'(quo), 32'd28);
    chk("held first rem", 32'(rem), 32'd4);
    @(posedge clk); #1;
    chk("held idle gap", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("held accepted", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("held second latency", 32'(lat), 32'd8);
    chk("held second quo", 32'(quo), 32'd17);
    chk("held second rem", 32'(rem), 32'd0);
    @(posedge clk); #1;

    // Asynchronous abort mid-CALC.
    @(negedge clk);
    start = 1'b1; dvd = 8'd200; dvs = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort quo", 32'(quo), 32'h00);
    chk("abort rem", 32'(rem), 32'h0);
    chk("abort div0", 32'(div0), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("abort no done", 32'(dcnt), 32'd0);
    run_op("13/4", 8'd13, 4'd4, 8'd3, 4'd1, 1'b0, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
